// File: rtl/xbar_route_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : xbar_route_ctrl_if
//  Purpose  : Command, status-query and AddressSelect bundle between the
//             upstream route manager and the crossbar route sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface xbar_route_ctrl_if #(
  parameter int IN_W   = 2,
  parameter int OUT_W  = 3,
  parameter int ADDR_W = 6
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [IN_W-1:0]   cmd_in;
  logic [OUT_W-1:0]  cmd_out;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] AddressSelect;
  logic [OUT_W-1:0]  qry_out;
  logic              qry_valid;
  logic [IN_W-1:0]   qry_owner;

  // Upstream side: issues commands and status queries
  modport master (
    output cmd_valid, cmd_op, cmd_in, cmd_out, qry_out,
    input  cmd_ready, done, err, AddressSelect, qry_valid, qry_owner
  );

  // Sequencer side: accepts commands and owns the crossbar select bus
  modport slave (
    input  cmd_valid, cmd_op, cmd_in, cmd_out, qry_out,
    output cmd_ready, done, err, AddressSelect, qry_valid, qry_owner
  );
endinterface
`default_nettype wire

// File: rtl/xbar_route_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : xbar_route_ctrl
//  Purpose  : Serialises crossbar reconfiguration. Keeps a shadow ownership
//             map of every crossbar output and turns connect / disconnect /
//             clear-all commands into single-cycle toggle addresses, each
//             followed by at least one cycle of the rest address.
//  Revision : 1.0 - initial release
// ============================================================================
module xbar_route_ctrl #(
  parameter int                IN_PORTS  = 4,
  parameter int                OUT_PORTS = 8,
  parameter int                IN_W      = 2,
  parameter int                OUT_W     = 3,
  parameter int                ADDR_W    = 6,
  parameter logic [ADDR_W-1:0] REST_ADDR = 6'h3F
) (
  input  wire logic        Clk,
  input  wire logic        Rst_n,
  xbar_route_ctrl_if.slave bus
);

  // Map is sized to the full index range so any cmd_out/qry_out value
  // indexes it safely; entries at or above OUT_PORTS are never set.
  localparam int               OUT_SLOTS     = 1 << OUT_W;
  localparam logic [1:0]       OP_CONNECT    = 2'b00;
  localparam logic [1:0]       OP_DISCONNECT = 2'b01;
  localparam logic [1:0]       OP_CLEAR      = 2'b10;
  localparam logic [1:0]       OP_ILLEGAL    = 2'b11;
  localparam logic [IN_W:0]    C_IN_LIM      = (IN_W+1)'(IN_PORTS);
  localparam logic [OUT_W:0]   C_OUT_LIM     = (OUT_W+1)'(OUT_PORTS);
  localparam logic [OUT_W-1:0] C_OUT_LAST    = OUT_W'(OUT_PORTS-1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNLINK = 3'd1,
    S_GAP    = 3'd2,
    S_LINK   = 3'd3,
    S_SCAN   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              done_q;
  logic              err_q;
  logic [1:0]        op_q;
  logic [IN_W-1:0]   in_q;
  logic [OUT_W-1:0]  out_q;
  logic              own_v_q   [OUT_SLOTS];
  logic [IN_W-1:0]   own_idx_q [OUT_SLOTS];

  logic              w_bad_cmd;
  logic              w_cmd_owned;
  logic [IN_W-1:0]   w_cmd_owner;
  logic [OUT_W-1:0]  w_scan_nxt;

  // Crossbar toggle address for the (input, output) crosspoint
  function automatic logic [ADDR_W-1:0] toggle_addr(input logic [IN_W-1:0]  i,
                                                    input logic [OUT_W-1:0] o);
    return ADDR_W'(i) * ADDR_W'(OUT_PORTS) + ADDR_W'(o);
  endfunction

  assign w_bad_cmd   = (bus.cmd_op == OP_ILLEGAL) ||
                       ({1'b0, bus.cmd_in}  >= C_IN_LIM) ||
                       ({1'b0, bus.cmd_out} >= C_OUT_LIM);
  assign w_cmd_owned = own_v_q[bus.cmd_out];
  assign w_cmd_owner = own_idx_q[bus.cmd_out];
  assign w_scan_nxt  = out_q + OUT_W'(1);

  assign bus.cmd_ready     = (state_q == S_IDLE);
  assign bus.done          = done_q;
  assign bus.err           = err_q;
  assign bus.AddressSelect = addr_q;
  assign bus.qry_valid     = own_v_q[bus.qry_out];
  assign bus.qry_owner     = own_v_q[bus.qry_out] ? own_idx_q[bus.qry_out] : '0;

  // Sequencer FSM: every output is registered and defaults to the rest
  // address, so a toggle address can only ever last a single cycle. The
  // clear-all walker looks one output ahead so an owned output costs exactly
  // its UNLINK and GAP cycles and an unowned output costs one SCAN cycle.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= REST_ADDR;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      op_q    <= OP_CONNECT;
      in_q    <= '0;
      out_q   <= '0;
      for (int i = 0; i < OUT_SLOTS; i++) begin
        own_v_q[i]   <= 1'b0;
        own_idx_q[i] <= '0;
      end
    end else begin
      addr_q <= REST_ADDR;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            op_q  <= bus.cmd_op;
            in_q  <= bus.cmd_in;
            out_q <= bus.cmd_out;
            if (bus.cmd_op == OP_CLEAR) begin
              out_q <= '0;
              if (own_v_q[0]) begin
                state_q <= S_UNLINK;
                addr_q  <= toggle_addr(own_idx_q[0], '0);
              end else begin
                state_q <= S_SCAN;
              end
            end else if (w_bad_cmd) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (bus.cmd_op == OP_CONNECT) begin
              if (!w_cmd_owned) begin
                state_q <= S_LINK;
                addr_q  <= toggle_addr(bus.cmd_in, bus.cmd_out);
              end else if (w_cmd_owner == bus.cmd_in) begin
                // Route already present: toggling would tear it down
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_UNLINK;
                addr_q  <= toggle_addr(w_cmd_owner, bus.cmd_out);
              end
            end else begin
              if (w_cmd_owned && (w_cmd_owner == bus.cmd_in)) begin
                state_q <= S_UNLINK;
                addr_q  <= toggle_addr(bus.cmd_in, bus.cmd_out);
              end else begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                err_q   <= 1'b1;
              end
            end
          end
        end
        S_UNLINK: begin
          own_v_q[out_q] <= 1'b0;
          if (op_q == OP_DISCONNECT) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_GAP;
          end
        end
        S_GAP, S_SCAN: begin
          if ((state_q == S_GAP) && (op_q != OP_CLEAR)) begin
            state_q <= S_LINK;
            addr_q  <= toggle_addr(in_q, out_q);
          end else if (out_q == C_OUT_LAST) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            out_q <= w_scan_nxt;
            if (own_v_q[w_scan_nxt]) begin
              state_q <= S_UNLINK;
              addr_q  <= toggle_addr(own_idx_q[w_scan_nxt], w_scan_nxt);
            end else begin
              state_q <= S_SCAN;
            end
          end
        end
        S_LINK: begin
          own_v_q[out_q]   <= 1'b1;
          own_idx_q[out_q] <= in_q;
          state_q          <= S_DONE;
          done_q           <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xbar_route_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xbar_route_ctrl
//  Purpose  : Directed self-checking bench for xbar_route_ctrl. The output
//             index field is built one bit wider than needed so out-of-range
//             output indices can be issued.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_xbar_route_ctrl;

  localparam logic [1:0] OP_CON = 2'b00;
  localparam logic [1:0] OP_DIS = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  logic Clk   = 1'b0;
  logic Rst_n = 1'b1;

  // Free-running clock
  always #5 Clk = ~Clk;

  xbar_route_ctrl_if #(.IN_W(2), .OUT_W(4), .ADDR_W(6)) bus ();

  xbar_route_ctrl #(
    .IN_PORTS (4),
    .OUT_PORTS(8),
    .IN_W     (2),
    .OUT_W    (4),
    .ADDR_W   (6),
    .REST_ADDR(6'h3F)
  ) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .bus  (bus)
  );

  int         total = 0;
  int         bad   = 0;
  logic [5:0] tr_addr [0:31];
  int         tr_lat;
  logic       tr_err;

  // Issue one command once the block is ready, then record AddressSelect for
  // every cycle after the accept edge until done (tr_addr[k] = cycle T+k).
  task automatic run_cmd(input logic [1:0] op, input logic [1:0] ci, input logic [3:0] co);
    int w;
    w = 0;
    while (bus.cmd_ready !== 1'b1 && w < 40) begin
      @(posedge Clk); #1;
      w++;
    end
    bus.cmd_op    = op;
    bus.cmd_in    = ci;
    bus.cmd_out   = co;
    bus.cmd_valid = 1'b1;
    @(posedge Clk); #1;
    bus.cmd_valid = 1'b0;
    tr_lat = -1;
    tr_err = 1'bx;
    for (int k = 0; k < 32; k++) tr_addr[k] = '0;
    for (int k = 1; k < 32; k++) begin
      tr_addr[k] = bus.AddressSelect;
      if (bus.done === 1'b1) begin
        tr_lat = k;
        tr_err = bus.err;
        break;
      end
      @(posedge Clk); #1;
    end
    total++;
    if (tr_lat < 0) begin
      bad++;
      $display("FAIL cmd_timeout op=%0d in=%0d out=%0d: done not seen, required within 31 cycles", op, ci, co);
    end
  endtask

  task automatic test_reset;
    #2 Rst_n = 1'b0;
    #1;
    total++;
    if (bus.AddressSelect !== 6'd63) begin bad++; $display("FAIL rst_addr got=%0d exp=63", bus.AddressSelect); end
    total++;
    if (bus.done !== 1'b0 || bus.err !== 1'b0) begin bad++; $display("FAIL rst_done_err got=%b%b exp=00", bus.done, bus.err); end
    bus.qry_out = 4'd0;
    #1;
    total++;
    if (bus.qry_valid !== 1'b0) begin bad++; $display("FAIL rst_qry got=%b exp=0", bus.qry_valid); end
    repeat (3) @(posedge Clk);
    #1 Rst_n = 1'b1;
    @(posedge Clk); #1;
    total++;
    if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", bus.cmd_ready); end
  endtask

  task automatic test_connect;
    run_cmd(OP_CON, 2'd1, 4'd3);
    total++;
    if (tr_lat !== 2) begin bad++; $display("FAIL conn_lat got=%0d exp=2", tr_lat); end
    total++;
    if (tr_addr[1] !== 6'd11 || tr_addr[2] !== 6'd63) begin
      bad++; $display("FAIL conn_addr got=%0d,%0d exp=11,63", tr_addr[1], tr_addr[2]);
    end
    total++;
    if (tr_err !== 1'b0) begin bad++; $display("FAIL conn_err got=%b exp=0", tr_err); end
    bus.qry_out = 4'd3;
    #1;
    total++;
    if (bus.qry_valid !== 1'b1 || bus.qry_owner !== 2'd1) begin
      bad++; $display("FAIL conn_qry got=%b/%0d exp=1/1", bus.qry_valid, bus.qry_owner);
    end
  endtask

  task automatic test_reroute;
    logic [5:0] exp_a [0:3];
    exp_a = '{6'd11, 6'd63, 6'd19, 6'd63};
    run_cmd(OP_CON, 2'd2, 4'd3);
    total++;
    if (tr_lat !== 4) begin bad++; $display("FAIL rerte_lat got=%0d exp=4", tr_lat); end
    for (int k = 1; k <= 4; k++) begin
      total++;
      if (tr_addr[k] !== exp_a[k-1]) begin
        bad++; $display("FAIL rerte_addr cycle=T+%0d got=%0d exp=%0d", k, tr_addr[k], exp_a[k-1]);
      end
    end
    bus.qry_out = 4'd3;
    #1;
    total++;
    if (bus.qry_valid !== 1'b1 || bus.qry_owner !== 2'd2) begin
      bad++; $display("FAIL rerte_qry got=%b/%0d exp=1/2", bus.qry_valid, bus.qry_owner);
    end
  endtask

  task automatic test_noop_and_errors;
    run_cmd(OP_CON, 2'd2, 4'd3);
    total++;
    if (tr_lat !== 1 || tr_err !== 1'b0 || tr_addr[1] !== 6'd63) begin
      bad++; $display("FAIL noop got lat=%0d err=%b addr=%0d exp lat=1 err=0 addr=63", tr_lat, tr_err, tr_addr[1]);
    end
    run_cmd(OP_DIS, 2'd0, 4'd3);
    total++;
    if (tr_lat !== 1 || tr_err !== 1'b1 || tr_addr[1] !== 6'd63) begin
      bad++; $display("FAIL dis_wrong got lat=%0d err=%b addr=%0d exp lat=1 err=1 addr=63", tr_lat, tr_err, tr_addr[1]);
    end
    bus.qry_out = 4'd3;
    #1;
    total++;
    if (bus.qry_valid !== 1'b1 || bus.qry_owner !== 2'd2) begin
      bad++; $display("FAIL dis_wrong_qry got=%b/%0d exp=1/2", bus.qry_valid, bus.qry_owner);
    end
    run_cmd(OP_ILL, 2'd0, 4'd0);
    total++;
    if (tr_lat !== 1 || tr_err !== 1'b1 || tr_addr[1] !== 6'd63) begin
      bad++; $display("FAIL op11 got lat=%0d err=%b addr=%0d exp lat=1 err=1 addr=63", tr_lat, tr_err, tr_addr[1]);
    end
    run_cmd(OP_CON, 2'd0, 4'd8);
    total++;
    if (tr_lat !== 1 || tr_err !== 1'b1 || tr_addr[1] !== 6'd63) begin
      bad++; $display("FAIL out8 got lat=%0d err=%b addr=%0d exp lat=1 err=1 addr=63", tr_lat, tr_err, tr_addr[1]);
    end
  endtask

  task automatic test_disconnect;
    run_cmd(OP_DIS, 2'd2, 4'd3);
    total++;
    if (tr_lat !== 2 || tr_err !== 1'b0) begin
      bad++; $display("FAIL dis_lat got lat=%0d err=%b exp lat=2 err=0", tr_lat, tr_err);
    end
    total++;
    if (tr_addr[1] !== 6'd19 || tr_addr[2] !== 6'd63) begin
      bad++; $display("FAIL dis_addr got=%0d,%0d exp=19,63", tr_addr[1], tr_addr[2]);
    end
    bus.qry_out = 4'd3;
    #1;
    total++;
    if (bus.qry_valid !== 1'b0) begin bad++; $display("FAIL dis_qry got=%b exp=0", bus.qry_valid); end
  endtask

  task automatic test_clear_all;
    logic [5:0] exp_a [0:10];
    exp_a = '{6'd0, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63, 6'd31, 6'd63, 6'd63};
    run_cmd(OP_CON, 2'd0, 4'd0);
    total++;
    if (tr_addr[1] !== 6'd0) begin bad++; $display("FAIL clr_setup0 got=%0d exp=0", tr_addr[1]); end
    run_cmd(OP_CON, 2'd3, 4'd7);
    total++;
    if (tr_addr[1] !== 6'd31) begin bad++; $display("FAIL clr_setup7 got=%0d exp=31", tr_addr[1]); end
    run_cmd(OP_CLR, 2'd0, 4'd0);
    total++;
    if (tr_lat !== 11 || tr_err !== 1'b0) begin
      bad++; $display("FAIL clr_lat got lat=%0d err=%b exp lat=11 err=0", tr_lat, tr_err);
    end
    for (int k = 1; k <= 11; k++) begin
      total++;
      if (tr_addr[k] !== exp_a[k-1]) begin
        bad++; $display("FAIL clr_addr cycle=T+%0d got=%0d exp=%0d", k, tr_addr[k], exp_a[k-1]);
      end
    end
    for (int o = 0; o < 8; o++) begin
      bus.qry_out = 4'(o);
      #1;
      total++;
      if (bus.qry_valid !== 1'b0) begin bad++; $display("FAIL clr_qry out=%0d got=%b exp=0", o, bus.qry_valid); end
    end
    run_cmd(OP_CLR, 2'd0, 4'd0);
    total++;
    if (tr_lat !== 9 || tr_err !== 1'b0) begin
      bad++; $display("FAIL clr_empty got lat=%0d err=%b exp lat=9 err=0", tr_lat, tr_err);
    end
  endtask

  task automatic test_back_to_back;
    run_cmd(OP_DIS, 2'd1, 4'd5);
    total++;
    if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL b2b_done_ready got=%b exp=0", bus.cmd_ready); end
    bus.cmd_op    = OP_CON;
    bus.cmd_in    = 2'd1;
    bus.cmd_out   = 4'd4;
    bus.cmd_valid = 1'b1;
    @(posedge Clk); #1;
    total++;
    if (bus.cmd_ready !== 1'b1 || bus.AddressSelect !== 6'd63) begin
      bad++; $display("FAIL b2b_not_taken got ready=%b addr=%0d exp ready=1 addr=63", bus.cmd_ready, bus.AddressSelect);
    end
    @(posedge Clk); #1;
    bus.cmd_valid = 1'b0;
    total++;
    if (bus.AddressSelect !== 6'd12) begin bad++; $display("FAIL b2b_link got=%0d exp=12", bus.AddressSelect); end
    @(posedge Clk); #1;
    total++;
    if (bus.done !== 1'b1 || bus.AddressSelect !== 6'd63) begin
      bad++; $display("FAIL b2b_done got done=%b addr=%0d exp done=1 addr=63", bus.done, bus.AddressSelect);
    end
  endtask

  task automatic test_reset_mid;
    run_cmd(OP_CON, 2'd1, 4'd2);
    total++;
    if (tr_addr[1] !== 6'd10) begin bad++; $display("FAIL rmid_setup got=%0d exp=10", tr_addr[1]); end
    @(posedge Clk); #1;
    bus.cmd_op    = OP_CON;
    bus.cmd_in    = 2'd3;
    bus.cmd_out   = 4'd2;
    bus.cmd_valid = 1'b1;
    @(posedge Clk); #1;
    bus.cmd_valid = 1'b0;
    total++;
    if (bus.AddressSelect !== 6'd10) begin bad++; $display("FAIL rmid_unlink got=%0d exp=10", bus.AddressSelect); end
    @(posedge Clk); #1;
    total++;
    if (bus.AddressSelect !== 6'd63) begin bad++; $display("FAIL rmid_gap got=%0d exp=63", bus.AddressSelect); end
    Rst_n       = 1'b0;
    bus.qry_out = 4'd4;
    #1;
    total++;
    if (bus.AddressSelect !== 6'd63 || bus.qry_valid !== 1'b0) begin
      bad++; $display("FAIL rmid_async got addr=%0d qv=%b exp addr=63 qv=0", bus.AddressSelect, bus.qry_valid);
    end
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge Clk); #1;
      total++;
      if (bus.AddressSelect !== 6'd63 || bus.cmd_ready !== 1'b1 || bus.done !== 1'b0) begin
        bad++; $display("FAIL rmid_quiet cycle=%0d got addr=%0d rdy=%b done=%b exp 63/1/0", k, bus.AddressSelect, bus.cmd_ready, bus.done);
      end
    end
    run_cmd(OP_CON, 2'd3, 4'd2);
    total++;
    if (tr_lat !== 2 || tr_addr[1] !== 6'd26) begin
      bad++; $display("FAIL rmid_after got lat=%0d addr=%0d exp lat=2 addr=26", tr_lat, tr_addr[1]);
    end
  endtask

  // Test sequence
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_in    = '0;
    bus.cmd_out   = '0;
    bus.qry_out   = '0;
    test_reset();
    test_connect();
    test_reroute();
    test_noop_and_errors();
    test_disconnect();
    test_clear_all();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
